dtcore32_regfile_mp: RTL and testbench
======================================

# dtcore32_regfile_mp

Parametrised multi-port integer register file for the dtcore32 pipeline, replacing the fixed 2-read/1-write file. It adds configurable width, depth and port counts, per-port write enables, optional same-cycle write-to-read bypass, and a per-register pending (scoreboard) bit. The decode stage uses the pending bit to stall on outstanding producers such as loads and multi-cycle ops. It sits between decode (reads, pending-set) and writeback (writes).

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers; power of two, ≥ 2; AW = $clog2(NREGS)
- NRD, 2, number of read ports (1–4)
- NWR, 1, number of write ports (1–2)
- BYPASS, 1, 1 = a read returns a same-cycle write to the same register; 0 = a read returns the stored value only

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- rd_addr_i  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW]
- rd_data_o  out  NRD*XLEN  read data, combinational
- rd_pend_o  out  NRD  pending bit of each read address, combinational
- wr_en_i  in  NWR  write enables
- wr_addr_i  in  NWR*AW  write addresses
- wr_data_i  in  NWR*XLEN  write data
- pend_set_i  in  1  mark register pend_addr_i as pending
- pend_addr_i  in  AW  register to mark as pending
- flush_i  in  1  clear all pending bits; synchronous

## Operation
- Register 0 is hardwired to 0.
  - Writes to it are dropped.
  - It is never pending. pend_set_i with pend_addr_i = 0 has no effect.
  - Reads of it return 0 with pending = 0, regardless of bypass.
- Write: when wr_en_i[j] = 1 and wr_addr_i[j] ≠ 0, reg[wr_addr_i[j]] takes wr_data_i[j] on the rising edge.
- Write-write collision (NWR = 2, same nonzero address, both enabled): port 1 wins. Port 0's data is discarded.
- Read, BYPASS = 1: if any enabled write targets rd_addr_i[k] (≠ 0), rd_data_o[k] is that write's data, using the same port-1 priority. Otherwise it is the stored value.
- Read, BYPASS = 0: rd_data_o[k] is always the stored value.
- Pending bits, one per register:
  - Set on the edge where pend_set_i = 1.
  - Cleared on the edge where any enabled write targets that register.
- Set and clear of the same register on the same edge: set wins, because a new producer has been issued.
- flush_i = 1 clears every pending bit on that edge and overrides a pend_set_i in the same cycle. Register contents are unaffected. Writes in the same cycle still commit.
- rd_pend_o[k] reflects the stored pending bit. When BYPASS = 1, it reads 0 if a same-cycle enabled write targets that register and no pend_set_i for that register is in progress.
- Read ports are independent. Any number of ports may read the same address.

## Timing
- Reset, asynchronous, while rst_i = 1:
  - All registers are 0 and all pending bits are 0.
  - Hence rd_data_o = 0 and rd_pend_o = 0 for all ports.
  - Writes, pend_set_i and flush_i are ignored.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge. Deassertion is synchronous to the design and has no other effect.
- Write latency: 1 edge to storage, 0 cycles to reads when BYPASS = 1, 1 cycle when BYPASS = 0.
- Pending latency: a set is visible on rd_pend_o on the cycle after the pend_set_i edge. A clear is visible the same cycle with BYPASS = 1 and the next cycle otherwise.
- All outputs are purely combinational from storage and the current inputs. No read latency.
- Out-of-range addresses cannot occur, because NREGS is a power of two.

## Test plan
- Reset:
  - Stimulus: write 0xDEADBEEF to x5, then pulse rst_i between clock edges.
  - Required response: read of x5 shows 0 before the next edge, and rd_pend_o = 0.
- x0:
  - Stimulus: wr_en = 1, addr 0, data 0xFFFFFFFF; also pend_set on x0.
  - Required response: a read of x0 returns 0 and pending = 0, both the same cycle and the next.
- Bypass:
  - Stimulus: BYPASS = 1, write 0x12345678 to x7 while port 0 reads x7.
  - Required response: rd_data_o = 0x12345678 in the same cycle. With BYPASS = 0 the same cycle returns the old value and the next cycle returns 0x12345678.
- Write collision:
  - Stimulus: NWR = 2, both ports write x3 with 0xAAAA0000 on port 0 and 0x0000BBBB on port 1.
  - Required response: x3 = 0x0000BBBB, and the bypassed read also shows 0x0000BBBB.
- Scoreboard:
  - Stimulus: pend_set x9 → rd_pend = 1 next cycle; write x9 while pend_set x9 in the same cycle.
  - Required response: x9 stays pending and holds the new data.
- Flush:
  - Stimulus: set pending on x4 and x10, then flush_i together with pend_set x11.
  - Required response: all rd_pend_o = 0 next cycle, and register data is unchanged.

Source files
------------

// File: rtl/dtcore32_regfile_mp.sv
// Multi-port integer register file with per-register pending (scoreboard) bits and optional write-to-read bypass.
// Latency: reads are combinational; writes and pending updates land on the next rising clk_i edge.
// Backpressure: none; every port is accepted every cycle, and decode stalls itself on rd_pend_o.
module dtcore32_regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_pend_o,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  input  logic                pend_set_i,
  input  logic [AW-1:0]       pend_addr_i,
  input  logic                flush_i
);

  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_nxt;

  // Commit writes; later ports are visited last so port 1 wins a collision. x0 is never written.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] != '0)) begin
          regs[wr_addr_i[j*AW +: AW]] <= wr_data_i[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Next pending vector: writes clear, a new producer sets (and beats a clear), flush clears everything.
  always_comb begin
    pend_nxt = pend_q;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en_i[j]) begin
        pend_nxt[wr_addr_i[j*AW +: AW]] = 1'b0;
      end
    end
    if (pend_set_i) begin
      pend_nxt[pend_addr_i] = 1'b1;
    end
    if (flush_i) begin
      pend_nxt = '0;
    end
    pend_nxt[0] = 1'b0;
  end

  // Pending scoreboard register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_nxt;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] data;
    logic            pend;
    logic            hit;

    assign ra = rd_addr_i[k*AW +: AW];

    // Stored value, optionally overridden by a same-cycle write (highest port wins); x0 always reads 0.
    always_comb begin
      data = regs[ra];
      pend = pend_q[ra];
      hit  = 1'b0;
      if (BYPASS != 0) begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] == ra)) begin
            data = wr_data_i[j*XLEN +: XLEN];
            hit  = 1'b1;
          end
        end
      end
      if (hit && !(pend_set_i && (pend_addr_i == ra))) begin
        pend = 1'b0;
      end
      if (ra == '0) begin
        data = '0;
        pend = 1'b0;
      end
    end

    assign rd_data_o[k*XLEN +: XLEN] = data;
    assign rd_pend_o[k]              = pend;
  end

endmodule

// File: tb/tb_dtcore32_regfile_mp.sv
module tb_dtcore32_regfile_mp;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int NWR   = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                pend_set;
  logic [AW-1:0]       pend_addr;
  logic                flush;

  logic [NRD*XLEN-1:0] data_b, data_n;
  logic [NRD-1:0]      pend_b, pend_n;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference state: architectural registers and scoreboard as plain arrays.
  logic [31:0] m_reg  [NREGS];
  bit          m_pend [NREGS];

  always #5 clk = ~clk;

  dtcore32_regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rd_data_o(data_b), .rd_pend_o(pend_b),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .pend_set_i(pend_set), .pend_addr_i(pend_addr), .flush_i(flush)
  );

  dtcore32_regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_n (
    .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rd_data_o(data_n), .rd_pend_o(pend_n),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .pend_set_i(pend_set), .pend_addr_i(pend_addr), .flush_i(flush)
  );

  typedef struct {
    logic [4:0]  r0, r1;
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        ps;
    logic [4:0]  pa;
    logic        fl;
    logic [31:0] e_d0;  // bypass instance, port 0 data
    logic        e_p0;  // bypass instance, port 0 pending
    logic [31:0] e_nb;  // non-bypass instance, port 0 data
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(input logic [4:0] r0, input logic [4:0] r1, input logic [1:0] we,
                              input logic [4:0] wa0, input logic [31:0] wd0,
                              input logic [4:0] wa1, input logic [31:0] wd1,
                              input logic ps, input logic [4:0] pa, input logic fl,
                              input logic [31:0] e_d0, input logic e_p0, input logic [31:0] e_nb);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.ps = ps; v.pa = pa; v.fl = fl; v.e_d0 = e_d0; v.e_p0 = e_p0; v.e_nb = e_nb;
    return v;
  endfunction

  function automatic bit wrote(input logic [4:0] a);
    return (wr_en[0] && wr_addr[4:0] == a) || (wr_en[1] && wr_addr[9:5] == a);
  endfunction

  function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
    if (a == 0) return 32'h0;
    if (byp) begin
      if (wr_en[1] && wr_addr[9:5] == a) return wr_data[63:32];
      if (wr_en[0] && wr_addr[4:0] == a) return wr_data[31:0];
    end
    return m_reg[a];
  endfunction

  function automatic logic exp_pend(input logic [4:0] a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && wrote(a) && !(pend_set && pend_addr == a)) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin
      m_reg[i]  = 32'h0;
      m_pend[i] = 1'b0;
    end
  endtask

  // Architectural effect of one clock edge with the inputs currently driven.
  task automatic model_commit();
    if (wr_en[0] && wr_addr[4:0] != 0) m_reg[wr_addr[4:0]] = wr_data[31:0];
    if (wr_en[1] && wr_addr[9:5] != 0) m_reg[wr_addr[9:5]] = wr_data[63:32];
    if (flush) begin
      for (int i = 0; i < NREGS; i++) m_pend[i] = 1'b0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (pend_set && pend_addr == i) m_pend[i] = 1'b1;
        else if (wrote(5'(i)))          m_pend[i] = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < NRD; k++) begin
      logic [4:0] a;
      a = rd_addr[k*AW +: AW];
      chk($sformatf("%s byp data p%0d x%0d", tag, k, a), data_b[k*XLEN +: XLEN], exp_data(a, 1'b1));
      chk($sformatf("%s byp pend p%0d x%0d", tag, k, a), 32'(pend_b[k]), 32'(exp_pend(a, 1'b1)));
      chk($sformatf("%s nob data p%0d x%0d", tag, k, a), data_n[k*XLEN +: XLEN], exp_data(a, 1'b0));
      chk($sformatf("%s nob pend p%0d x%0d", tag, k, a), 32'(pend_n[k]), 32'(exp_pend(a, 1'b0)));
    end
  endtask

  task automatic drive(input logic [4:0] r0, input logic [4:0] r1, input logic [1:0] we,
                       input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic ps, input logic [4:0] pa, input logic fl);
    rd_addr   = {r1, r0};
    wr_en     = we;
    wr_addr   = {wa1, wa0};
    wr_data   = {wd1, wd0};
    pend_set  = ps;
    pend_addr = pa;
    flush     = fl;
  endtask

  // Called shortly after a rising edge: check outputs mid-cycle, then take the edge.
  task automatic step(input string tag);
    #2;
    check_all(tag);
    @(posedge clk);
    model_commit();
    #1;
  endtask

  initial begin
    model_reset();
    drive(5'd5, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    #3;
    check_all("reset");
    #9;
    rst = 1'b0;

    // Directed table: x0, bypass, collision, scoreboard, flush.
    tbl[0]  = mk(5'd0,  5'd0,  2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0,  1'b0, 32'h0,        1'b0, 32'h0);
    tbl[1]  = mk(5'd0,  5'd1,  2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0,        1'b1, 5'd0,  1'b0, 32'h0,        1'b0, 32'h0);
    tbl[2]  = mk(5'd0,  5'd0,  2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0,  1'b0, 32'h0,        1'b0, 32'h0);
    tbl[3]  = mk(5'd7,  5'd7,  2'b01, 5'd7, 32'h12345678, 5'd0, 32'h0,        1'b0, 5'd0,  1'b0, 32'h12345678, 1'b0, 32'h0);
    tbl[4]  = mk(5'd7,  5'd0,  2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0,  1'b0, 32'h12345678, 1'b0, 32'h12345678);
    tbl[5]  = mk(5'd3,  5'd7,  2'b11, 5'd3, 32'hAAAA0000, 5'd3, 32'h0000BBBB, 1'b0, 5'd0,  1'b0, 32'h0000BBBB, 1'b0, 32'h0);
    tbl[6]  = mk(5'd3,  5'd3,  2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0,  1'b0, 32'h0000BBBB, 1'b0, 32'h0000BBBB);
    tbl[7]  = mk(5'd9,  5'd3,  2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b1, 5'd9,  1'b0, 32'h0,        1'b0, 32'h0);
    tbl[8]  = mk(5'd9,  5'd9,  2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0,  1'b0, 32'h0,        1'b1, 32'h0);
    tbl[9]  = mk(5'd9,  5'd0,  2'b01, 5'd9, 32'hCAFEF00D, 5'd0, 32'h0,        1'b1, 5'd9,  1'b0, 32'hCAFEF00D, 1'b1, 32'h0);
    tbl[10] = mk(5'd9,  5'd7,  2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0,  1'b0, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D);
    tbl[11] = mk(5'd9,  5'd9,  2'b10, 5'd0, 32'h0,        5'd9, 32'h11111111, 1'b0, 5'd0,  1'b0, 32'h11111111, 1'b0, 32'hCAFEF00D);
    tbl[12] = mk(5'd9,  5'd0,  2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0,  1'b0, 32'h11111111, 1'b0, 32'h11111111);
    tbl[13] = mk(5'd4,  5'd10, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b1, 5'd4,  1'b0, 32'h0,        1'b0, 32'h0);
    tbl[14] = mk(5'd4,  5'd10, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b1, 5'd10, 1'b0, 32'h0,        1'b1, 32'h0);
    tbl[15] = mk(5'd10, 5'd4,  2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b1, 5'd11, 1'b1, 32'h0,        1'b1, 32'h0);
    tbl[16] = mk(5'd11, 5'd10, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0,  1'b0, 32'h0,        1'b0, 32'h0);
    tbl[17] = mk(5'd4,  5'd9,  2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0,  1'b0, 32'h0,        1'b0, 32'h0);
    tbl[18] = mk(5'd7,  5'd3,  2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0,  1'b0, 32'h12345678, 1'b0, 32'h12345678);

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].r0, tbl[i].r1, tbl[i].we, tbl[i].wa0, tbl[i].wd0, tbl[i].wa1, tbl[i].wd1,
            tbl[i].ps, tbl[i].pa, tbl[i].fl);
      #2;
      chk($sformatf("tbl%0d byp d0", i), data_b[31:0], tbl[i].e_d0);
      chk($sformatf("tbl%0d byp p0", i), 32'(pend_b[0]), 32'(tbl[i].e_p0));
      chk($sformatf("tbl%0d nob d0", i), data_n[31:0], tbl[i].e_nb);
      check_all($sformatf("tbl%0d", i));
      @(posedge clk);
      model_commit();
      #1;
    end

    // Asynchronous reset between edges: x5 written and marked pending, then rst pulsed mid-cycle.
    drive(5'd5, 5'd0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0);
    step("pre_rst");
    drive(5'd5, 5'd5, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    #1;
    chk("x5 before rst", data_n[31:0], 32'hDEADBEEF);
    chk("x5 pend before rst", 32'(pend_n[0]), 32'h1);
    rst = 1'b1;
    #1;
    chk("x5 during rst byp", data_b[31:0], 32'h0);
    chk("x5 during rst nob", data_n[31:0], 32'h0);
    chk("x5 pend during rst", 32'({pend_b, pend_n}), 32'h0);
    model_reset();
    rst = 1'b0;
    check_all("post_rst");
    @(posedge clk);
    model_commit();
    #1;

    // Randomized traffic against the reference model; narrow address range forces collisions.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] lim;
      lim = (n % 2 == 0) ? 5'd7 : 5'd31;
      drive(5'($urandom_range(0, lim)), 5'($urandom_range(0, lim)), 2'($urandom_range(0, 3)),
            5'($urandom_range(0, lim)), $urandom, 5'($urandom_range(0, lim)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, lim)), ($urandom_range(0, 15) == 0));
      step($sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
